// File: rtl/m_cycleacc.sv
// m_cycleacc: 64-bit cycle and retired-instruction counters, each split into
// 32-bit lo/hi words. The carry into a hi word is registered, so the hi word
// updates one edge after the lo word wraps.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   corerunning         retire pulses are ignored while low
//   retire, ccnt[5:0]   instruction retired this cycle and the cycles it used
//   rd_req, rd_sel[1:0] read request; 0 cyc_lo, 1 cyc_hi, 2 ret_lo, 3 ret_hi
//   rd_ack, rd_data     one-cycle read acknowledge and registered read data
//   wr_req, wr_sel[1:0] write request (same word encoding as rd_sel)
//   wr_data[31:0]       write data
//   wr_ack              one-cycle write acknowledge
//   carry_pend          a hi-word carry is waiting to be applied
module m_cycleacc #(
    parameter int unsigned NO_CYCLECNT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        corerunning,
    input  logic        retire,
    input  logic [5:0]  ccnt,
    input  logic        rd_req,
    input  logic [1:0]  rd_sel,
    output logic        rd_ack,
    output logic [31:0] rd_data,
    input  logic        wr_req,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic        carry_pend
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } rd_state_e;

    rd_state_e   state_q, state_d;
    logic [31:0] cyc_lo_q, cyc_lo_d;
    logic [31:0] cyc_hi_q, cyc_hi_d;
    logic [31:0] ret_lo_q, ret_lo_d;
    logic [31:0] ret_hi_q, ret_hi_d;
    logic        cy_c_q, cy_c_d;
    logic        cy_r_q, cy_r_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_ack_q, rd_ack_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  rd_psel_q, rd_psel_d;

    logic        ret_acc;
    logic        wr_cl, wr_ch, wr_rl, wr_rh;
    logic [31:0] cyc_inc;
    logic [32:0] cyc_sum, ret_sum;
    logic        rd_go;
    logic [1:0]  sel_eff;
    logic        sel_hi_pend;

    function automatic logic [31:0] word_mux(input logic [1:0] sel,
                                             input logic [31:0] w0,
                                             input logic [31:0] w1,
                                             input logic [31:0] w2,
                                             input logic [31:0] w3);
        logic [31:0] r;
        unique case (sel)
            2'd0:    r = w0;
            2'd1:    r = w1;
            2'd2:    r = w2;
            default: r = w3;
        endcase
        return r;
    endfunction

    // Counter datapath
    always_comb begin
        ret_acc = retire & corerunning;
        wr_cl   = wr_req && (wr_sel == 2'd0);
        wr_ch   = wr_req && (wr_sel == 2'd1);
        wr_rl   = wr_req && (wr_sel == 2'd2);
        wr_rh   = wr_req && (wr_sel == 2'd3);

        cyc_inc = (NO_CYCLECNT != 0) ? 32'd1 : {26'b0, ccnt};
        cyc_sum = {1'b0, cyc_lo_q} + {1'b0, cyc_inc};
        ret_sum = {1'b0, ret_lo_q} + 33'd1;

        // A write to a lo word overrides that counter's increment and
        // suppresses its carry; the other counter is unaffected.
        cyc_lo_d = wr_cl ? wr_data : (ret_acc ? cyc_sum[31:0] : cyc_lo_q);
        ret_lo_d = wr_rl ? wr_data : (ret_acc ? ret_sum[31:0] : ret_lo_q);
        cy_c_d   = ret_acc & ~wr_cl & cyc_sum[32];
        cy_r_d   = ret_acc & ~wr_rl & ret_sum[32];

        // A pending carry is consumed every edge; a hi write discards it.
        cyc_hi_d = wr_ch ? wr_data : cyc_hi_q + {31'b0, cy_c_q};
        ret_hi_d = wr_rh ? wr_data : ret_hi_q + {31'b0, cy_r_q};

        wr_ack_d = wr_req;
    end

    // Read FSM. A read colliding with a write is parked in rd_pend_q so it
    // is served in the next cycle even if rd_req has already dropped.
    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        rd_ack_d    = 1'b0;
        rd_pend_d   = rd_pend_q;
        rd_psel_d   = rd_psel_q;

        rd_go       = rd_req | rd_pend_q;
        sel_eff     = rd_pend_q ? rd_psel_q : rd_sel;
        sel_hi_pend = ((sel_eff == 2'd1) && cy_c_q) ||
                      ((sel_eff == 2'd3) && cy_r_q);

        unique case (state_q)
            S_IDLE: begin
                if (rd_go) begin
                    rd_psel_d = sel_eff;
                    if (wr_req) begin
                        rd_pend_d = 1'b1;
                    end else begin
                        rd_pend_d = 1'b0;
                        if (sel_hi_pend) begin
                            state_d = S_WAIT;
                        end else begin
                            rd_data_d = word_mux(sel_eff, cyc_lo_q, cyc_hi_q,
                                                 ret_lo_q, ret_hi_q);
                            rd_ack_d  = 1'b1;
                            state_d   = S_ACK;
                        end
                    end
                end
            end
            S_WAIT: begin
                // hi word has absorbed its carry by now
                rd_data_d = word_mux(rd_psel_q, cyc_lo_q, cyc_hi_q,
                                     ret_lo_q, ret_hi_q);
                rd_ack_d  = 1'b1;
                state_d   = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_lo_q  <= '0;
            cyc_hi_q  <= '0;
            ret_lo_q  <= '0;
            ret_hi_q  <= '0;
            cy_c_q    <= 1'b0;
            cy_r_q    <= 1'b0;
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_psel_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_lo_q  <= cyc_lo_d;
            cyc_hi_q  <= cyc_hi_d;
            ret_lo_q  <= ret_lo_d;
            ret_hi_q  <= ret_hi_d;
            cy_c_q    <= cy_c_d;
            cy_r_q    <= cy_r_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            rd_pend_q <= rd_pend_d;
            rd_psel_q <= rd_psel_d;
        end
    end

    assign rd_ack     = rd_ack_q;
    assign rd_data    = rd_data_q;
    assign wr_ack     = wr_ack_q;
    assign carry_pend = cy_c_q | cy_r_q;

endmodule

// File: tb/tb_m_cycleacc.sv
module tb_m_cycleacc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        corerunning;
    logic        retire;
    logic [5:0]  ccnt;
    logic        rd_req;
    logic [1:0]  rd_sel;
    logic        wr_req;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;

    logic        rd_ack0, rd_ack1;
    logic [31:0] rd_data0, rd_data1;
    logic        wr_ack0, wr_ack1;
    logic        carry_pend0, carry_pend1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_cycleacc #(.NO_CYCLECNT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .corerunning(corerunning), .retire(retire),
        .ccnt(ccnt), .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack0),
        .rd_data(rd_data0), .wr_req(wr_req), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_ack(wr_ack0), .carry_pend(carry_pend0)
    );

    m_cycleacc #(.NO_CYCLECNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .corerunning(corerunning), .retire(retire),
        .ccnt(ccnt), .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack1),
        .rd_data(rd_data1), .wr_req(wr_req), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_ack(wr_ack1), .carry_pend(carry_pend1)
    );

    typedef struct {
        logic        cr;
        int unsigned n;
        logic [5:0]  cc;
        logic [31:0] e_cyc0;
        logic [31:0] e_cyc1;
        logic [31:0] e_ret;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; corerunning = 1'b1; retire = 1'b0; ccnt = '0;
        rd_req = 1'b0; rd_sel = '0; wr_req = 1'b0; wr_sel = '0; wr_data = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_write(input logic [1:0] sel, input logic [31:0] d);
        wr_req = 1'b1; wr_sel = sel; wr_data = d;
        @(negedge clk);
        wr_req = 1'b0;
        check("wr_ack", {31'b0, wr_ack0}, 32'd1);
    endtask

    task automatic do_retire(input logic cr, input int unsigned n,
                             input logic [5:0] c);
        for (int unsigned i = 0; i < n; i++) begin
            corerunning = cr; retire = 1'b1; ccnt = c;
            @(negedge clk);
        end
        retire = 1'b0; corerunning = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] sel, output logic [31:0] d0,
                           output logic [31:0] d1);
        bit g0, g1;
        g0 = 1'b0; g1 = 1'b0; d0 = '0; d1 = '0;
        rd_req = 1'b1; rd_sel = sel;
        @(negedge clk);
        rd_req = 1'b0;
        for (int i = 0; i < 8 && !(g0 && g1); i++) begin
            if (rd_ack0 && !g0) begin g0 = 1'b1; d0 = rd_data0; end
            if (rd_ack1 && !g1) begin g1 = 1'b1; d1 = rd_data1; end
            if (!(g0 && g1)) @(negedge clk);
        end
        if (!(g0 && g1)) begin
            checks++; errors++;
            $display("FAIL rd_timeout: got ack0=%0d ack1=%0d expected both 1", g0, g1);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b;
        int acks;

        tbl[0] = '{cr: 1'b1, n: 3, cc: 6'd5,  e_cyc0: 32'd15,  e_cyc1: 32'd3, e_ret: 32'd3};
        tbl[1] = '{cr: 1'b0, n: 4, cc: 6'd9,  e_cyc0: 32'd15,  e_cyc1: 32'd3, e_ret: 32'd3};
        tbl[2] = '{cr: 1'b1, n: 2, cc: 6'd40, e_cyc0: 32'd95,  e_cyc1: 32'd5, e_ret: 32'd5};
        tbl[3] = '{cr: 1'b1, n: 1, cc: 6'd63, e_cyc0: 32'd158, e_cyc1: 32'd6, e_ret: 32'd6};

        do_reset();
        check("rst_rd_ack", {31'b0, rd_ack0}, 32'd0);
        check("rst_wr_ack", {31'b0, wr_ack0}, 32'd0);
        check("rst_carry", {31'b0, carry_pend0}, 32'd0);
        check("rst_rd_data", rd_data0, 32'd0);

        // Retire bursts, cumulative; dut1 counts one cycle per retire
        for (int r = 0; r < 4; r++) begin
            do_retire(tbl[r].cr, tbl[r].n, tbl[r].cc);
            do_read(2'd0, a, b);
            check("tbl_cyc_lo", a, tbl[r].e_cyc0);
            check("tbl_cyc_lo_nocc", b, tbl[r].e_cyc1);
            do_read(2'd2, a, b);
            check("tbl_ret_lo", a, tbl[r].e_ret);
            do_read(2'd1, a, b);
            check("tbl_cyc_hi", a, 32'd0);
            do_read(2'd3, a, b);
            check("tbl_ret_hi", a, 32'd0);
        end

        // cyc_lo wrap, carry latency, and hi read stalled behind the carry
        do_reset();
        do_write(2'd0, 32'hFFFF_FFF0);
        retire = 1'b1; ccnt = 6'd20;
        @(negedge clk);
        retire = 1'b0;
        check("wrap_carry_pend", {31'b0, carry_pend0}, 32'd1);
        rd_req = 1'b1; rd_sel = 2'd1;
        @(negedge clk);
        rd_req = 1'b0;
        check("wrap_carry_clear", {31'b0, carry_pend0}, 32'd0);
        check("wait_no_ack", {31'b0, rd_ack0}, 32'd0);
        @(negedge clk);
        check("wait_ack", {31'b0, rd_ack0}, 32'd1);
        check("wait_data_hi", rd_data0, 32'd1);
        @(negedge clk);
        check("ack_one_cycle", {31'b0, rd_ack0}, 32'd0);
        check("rd_data_hold", rd_data0, 32'd1);
        do_read(2'd0, a, b);
        check("wrap_cyc_lo", a, 32'h0000_0004);
        check("wrap_cyc_lo_nocc", b, 32'hFFFF_FFF1);

        // Read of lo word coinciding with a retire sees the old value
        rd_req = 1'b1; rd_sel = 2'd2; retire = 1'b1; ccnt = 6'd3;
        @(negedge clk);
        rd_req = 1'b0; retire = 1'b0;
        check("rd_pre_inc_ack", {31'b0, rd_ack0}, 32'd1);
        check("rd_pre_inc", rd_data0, 32'd1);
        @(negedge clk);

        // Write to lo word wins over a simultaneous retire
        wr_req = 1'b1; wr_sel = 2'd0; wr_data = 32'h100; retire = 1'b1; ccnt = 6'd7;
        @(negedge clk);
        wr_req = 1'b0; retire = 1'b0;
        check("wr_retire_ack", {31'b0, wr_ack0}, 32'd1);
        @(negedge clk);
        check("wr_ack_pulse", {31'b0, wr_ack0}, 32'd0);
        do_read(2'd0, a, b);
        check("wr_wins_lo", a, 32'h100);
        do_read(2'd2, a, b);
        check("wr_other_inc", a, 32'd3);
        do_read(2'd1, a, b);
        check("wr_cyc_hi_keep", a, 32'd1);

        // Write has priority; colliding read served afterwards
        wr_req = 1'b1; wr_sel = 2'd2; wr_data = 32'h0000_ABCD;
        rd_req = 1'b1; rd_sel = 2'd2;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        check("prio_no_ack", {31'b0, rd_ack0}, 32'd0);
        acks = 0;
        for (int i = 0; i < 6 && acks == 0; i++) begin
            @(negedge clk);
            if (rd_ack0) acks = 1;
        end
        check("prio_ack_seen", acks, 32'd1);
        check("prio_data", rd_data0, 32'h0000_ABCD);
        @(negedge clk);

        // Writing a hi word discards its pending carry
        do_write(2'd0, 32'hFFFF_FFFF);
        do_retire(1'b1, 1, 6'd1);
        wr_req = 1'b1; wr_sel = 2'd1; wr_data = 32'h77;
        @(negedge clk);
        wr_req = 1'b0;
        check("hi_wr_carry_clr", {31'b0, carry_pend0}, 32'd0);
        do_read(2'd1, a, b);
        check("hi_wr_wins", a, 32'h77);

        // Writing a lo word keeps a pending carry
        do_write(2'd0, 32'hFFFF_FFFF);
        do_retire(1'b1, 1, 6'd1);
        do_write(2'd0, 32'd5);
        do_read(2'd1, a, b);
        check("lo_wr_keep_carry", a, 32'h78);
        do_read(2'd0, a, b);
        check("lo_wr_value", a, 32'd5);

        // Back-to-back retires across the ret_lo wrap
        do_write(2'd2, 32'hFFFF_FFFE);
        do_retire(1'b1, 4, 6'd1);
        do_read(2'd2, a, b);
        check("b2b_ret_lo", a, 32'd2);
        do_read(2'd3, a, b);
        check("b2b_ret_hi", a, 32'd1);
        check("b2b_ret_hi_nocc", b, 32'd1);

        // Reset while the read FSM is waiting on a carry
        do_write(2'd0, 32'hFFFF_FFFF);
        do_retire(1'b1, 1, 6'd2);
        rd_req = 1'b1; rd_sel = 2'd1;
        @(negedge clk);
        rd_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_carry", {31'b0, carry_pend0}, 32'd0);
        check("mid_rst_ack", {31'b0, rd_ack0}, 32'd0);
        check("mid_rst_data", rd_data0, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_ack0) acks++;
        end
        check("post_rst_no_ack", acks, 32'd0);
        do_read(2'd1, a, b);
        check("post_rst_cyc_hi", a, 32'd0);
        do_read(2'd0, a, b);
        check("post_rst_cyc_lo", a, 32'd0);
        do_read(2'd2, a, b);
        check("post_rst_ret_lo", a, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/m_cycleacc.md
M_CYCLEACC -- requirements
Module: m_cycleacc

Interface
REQ-001 SHALL have parameter NO_CYCLECNT, default 0, meaning 0 = accumulate ccnt per retire and 1 = accumulate 1 per retire.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port corerunning  input  1  core released; retire ignored when 0.
REQ-005 SHALL have port retire  input  1  one-cycle pulse, instruction completed this cycle.
REQ-006 SHALL have port ccnt  input  6  cycles used by retiring instruction, valid with retire, 1..63.
REQ-007 SHALL have ports rd_req  input  1, and rd_sel  input  2, where rd_sel selects 0 cyc_lo, 1 cyc_hi, 2 ret_lo, 3 ret_hi.
REQ-008 SHALL have ports rd_ack  output  1  one-cycle pulse, and rd_data  output  32  registered read data.
REQ-009 SHALL have ports wr_req  input  1, wr_sel  input  2  (same encoding as rd_sel), and wr_data  input  32.
REQ-010 SHALL have port wr_ack  output  1  one-cycle pulse.
REQ-011 SHALL have port carry_pend  output  1  high when either high-word carry is pending.

Function
REQ-012 SHALL hold four 32-bit registers cyc_lo, cyc_hi, ret_lo, ret_hi, forming two 64-bit counters (cycle, instret).
REQ-013 SHALL accept a retire only when retire=1 and corerunning=1; accepted retire: cyc_lo += {26'b0,ccnt} (NO_CYCLECNT=1: += 1), ret_lo += 1, at the same edge.
REQ-014 SHALL register the carry-out of each low-word add into flags cy_c and cy_r; on the next edge the corresponding hi += 1 and the flag clears (one-cycle carry latency).
REQ-015 SHALL support back-to-back retires every cycle without loss: after a wrap lo <= 62, so no second carry occurs before the pending one is applied.
REQ-016 SHALL implement the read FSM with states IDLE, WAIT, ACK: from IDLE with rd_req=1 and no write this cycle, go to WAIT if the selected word is hi with its carry pending, otherwise to ACK, capturing rd_data.
REQ-017 SHALL leave WAIT after exactly one cycle, capturing rd_data from the updated hi word, and go to ACK.
REQ-018 SHALL in ACK assert rd_ack for one cycle and return to IDLE; rd_req still high in IDLE SHALL be treated as a new request.
REQ-019 SHALL return, for a read of a lo word requested in the same cycle as an accepted retire, the pre-increment value.
REQ-020 SHALL keep rd_data stable from its ack until the next capture.
REQ-021 SHALL on wr_req=1 write wr_data into the selected word at the next edge and assert wr_ack one cycle; wr_req held high after ack SHALL be a new write.
REQ-022 SHALL, on a write to a lo word coinciding with an accepted retire, let the written value win, drop that increment and generate no carry; the other counter still increments.
REQ-023 SHALL, on a write to a hi word, let the written value win and clear its pending carry flag; a write to a lo word SHALL NOT clear a pending carry.
REQ-024 SHALL give a write priority over a simultaneous read request; the read is served starting the cycle after the write.
REQ-025 SHALL drive carry_pend = cy_c | cy_r combinationally from flags.

Reset
REQ-026 SHALL on rst_n=0 immediately clear all four counters, cy_c, cy_r, rd_data, rd_ack, wr_ack, and force the read FSM to IDLE, regardless of clk.
REQ-027 SHALL, when reset occurs mid-read (WAIT or ACK), produce no rd_ack after reset release until a new rd_req.
REQ-028 SHALL accept retires and requests from the first rising edge after rst_n rises.

Verification
REQ-029 SHALL be covered by: reset, corerunning=1, 3 retires ccnt=5 -> cyc_lo=15, ret_lo=3, hi words 0.
REQ-030 SHALL be covered by: write cyc_lo=0xFFFFFFF0, retire ccnt=20 -> cyc_lo=0x00000004, carry_pend=1 one cycle, then cyc_hi=1.
REQ-031 SHALL be covered by: rd_req rd_sel=1 in the carry_pend cycle of REQ-030 -> rd_ack 2 cycles later, rd_data=0x00000001.
REQ-032 SHALL be covered by: wr_req wr_sel=0 wr_data=0x100 with retire ccnt=7 same cycle -> cyc_lo=0x100, ret_lo incremented, wr_ack next cycle.
REQ-033 SHALL be covered by: corerunning=0 with retire pulses -> all counters unchanged; NO_CYCLECNT=1 with ccnt=40 -> cyc_lo +1 per retire.
REQ-034 SHALL be covered by: rst_n low during WAIT -> counters 0, rd_ack never asserted, carry_pend=0.
